// File: rtl/program_mem_sync_pkg.sv
// Shared definitions for the synchronous program memory: FSM encoding and the
// default base address / NOP word also used by the PC and decoder.
package program_mem_sync_pkg;

  typedef enum logic {
    PM_LOAD = 1'b0,
    PM_RUN  = 1'b1
  } pm_state_e;

  localparam logic [31:0] PM_BASE_ADDR_DEF = 32'h0000_0800;
  localparam logic [31:0] PM_NOP_WORD_DEF  = 32'h0000_0000;

endpackage

// File: rtl/program_mem_sync_array.sv
// Single-port synchronous RAM with registered read; kept reset-free so it maps
// onto FPGA block RAM.
module program_mem_sync_array #(
  parameter int unsigned DATA_WIDTH = 32'd32,
  parameter int unsigned DEPTH_LOG2 = 32'd6
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port and read register share one address; the caller never enables both.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/program_mem_sync.sv
// Synchronous instruction memory for the fetch stage: boot-load phase, then
// write-protected registered reads with valid/fault reporting.
module program_mem_sync
  import program_mem_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32'd32,
  parameter int unsigned ADDR_WIDTH = 32'd32,
  parameter int unsigned DEPTH_LOG2 = 32'd6,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(PM_BASE_ADDR_DEF),
  parameter logic [DATA_WIDTH-1:0] NOP_WORD  = DATA_WIDTH'(PM_NOP_WORD_DEF)
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_InLow,
  input  logic [ADDR_WIDTH-1:0] BusDirecciones,
  input  logic                  FetchReq,
  output logic [DATA_WIDTH-1:0] BusDatos,
  output logic                  FetchValid,
  output logic                  FetchFault,
  output logic                  FetchStall,
  input  logic                  LoadWe,
  input  logic [ADDR_WIDTH-1:0] LoadAddr,
  input  logic [DATA_WIDTH-1:0] LoadData,
  input  logic                  LoadDone,
  output logic [DEPTH_LOG2:0]   LoadCount
);

  localparam logic [DEPTH_LOG2:0] CNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  pm_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] fetch_off_s;
  logic [ADDR_WIDTH-1:0] load_off_s;
  logic                  fetch_in_range_s;
  logic                  load_in_range_s;
  logic                  fetch_take_s;
  logic                  load_take_s;
  logic                  ram_we_s;
  logic                  ram_re_s;
  logic [DEPTH_LOG2-1:0] ram_addr_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s;

  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;
  logic                  hit_q, hit_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  // Unsigned offset check: below BASE_ADDR the subtraction wraps and is rejected
  // by the first term, so no address aliases into the array.
  assign fetch_off_s      = BusDirecciones - BASE_ADDR;
  assign load_off_s       = LoadAddr - BASE_ADDR;
  assign fetch_in_range_s = (BusDirecciones >= BASE_ADDR) &&
                            (fetch_off_s[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
  assign load_in_range_s  = (LoadAddr >= BASE_ADDR) &&
                            (load_off_s[ADDR_WIDTH-1:DEPTH_LOG2] == '0);

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      state_q <= PM_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: LOAD exits once on LoadDone, RUN is left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PM_LOAD: begin
        if (LoadDone) begin
          state_d = PM_RUN;
        end else begin
          state_d = PM_LOAD;
        end
      end
      PM_RUN:  state_d = PM_RUN;
      default: state_d = PM_LOAD;
    endcase
  end

  // State outputs: which port owns the RAM this cycle.
  always_comb begin
    FetchStall   = 1'b0;
    load_take_s  = 1'b0;
    fetch_take_s = 1'b0;
    ram_addr_s   = fetch_off_s[DEPTH_LOG2-1:0];
    case (state_q)
      PM_LOAD: begin
        FetchStall  = 1'b1;
        load_take_s = LoadWe && load_in_range_s;
        ram_addr_s  = load_off_s[DEPTH_LOG2-1:0];
      end
      PM_RUN: begin
        fetch_take_s = FetchReq;
      end
      default: begin
        FetchStall = 1'b1;
      end
    endcase
  end

  assign ram_we_s = load_take_s;
  assign ram_re_s = fetch_take_s && fetch_in_range_s;

  // Response and load-count next state; hit_q selects RAM data over NOP_WORD.
  always_comb begin
    valid_d = fetch_take_s;
    if (fetch_take_s) begin
      fault_d = !fetch_in_range_s;
      hit_d   = fetch_in_range_s;
    end else begin
      fault_d = fault_q;
      hit_d   = hit_q;
    end
    if (load_take_s && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Response and counter registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      hit_q   <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      fault_q <= fault_d;
      hit_q   <= hit_d;
      count_q <= count_d;
    end
  end

  program_mem_sync_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk_i   (CLOCK_50),
    .we_i    (ram_we_s),
    .re_i    (ram_re_s),
    .addr_i  (ram_addr_s),
    .wdata_i (LoadData),
    .rdata_o (ram_rdata_s)
  );

  assign BusDatos   = hit_q ? ram_rdata_s : NOP_WORD;
  assign FetchValid = valid_q;
  assign FetchFault = fault_q;
  assign LoadCount  = count_q;

endmodule
